// File: rtl/ah_div_arbiter.sv
// Round-robin front end that shares one pipelined signed divider among NREQ clients
// and steers each result back to its issuer through a latency-matched tag delay line.
module ah_div_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 64,
    parameter int LATENCY = 11,
    parameter int MAX_OUT = 11
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    enable,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_dividend,
    input  logic [NREQ*WIDTH-1:0]   req_divisor,
    output logic [NREQ-1:0]         gnt,
    output logic                    div_start,
    output logic [WIDTH-1:0]        div_dividend,
    output logic [WIDTH-1:0]        div_divisor,
    input  logic                    div_data_valid,
    input  logic [WIDTH-1:0]        div_quotient,
    input  logic                    div_by_zero,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]        rsp_quotient,
    output logic                    rsp_div_by_zero,
    output logic                    busy,
    output logic                    err
);

    localparam int          IDW = $clog2(NREQ);
    localparam int          CW  = $clog2(MAX_OUT + 1);
    localparam int unsigned NR  = NREQ;

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]    out_cnt_q, out_cnt_d;
    logic             div_start_q;
    logic [WIDTH-1:0] div_dividend_q, div_divisor_q;
    logic [IDW-1:0]   issue_id_q;
    logic [LATENCY-1:0] tag_v_q;
    logic [IDW-1:0]   tag_id_q [LATENCY];
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_quotient_q;
    logic             rsp_div_by_zero_q;
    logic             busy_q;
    logic             err_q, err_d;

    logic             gnt_en;
    logic             found;
    logic [IDW-1:0]   gnt_id;
    logic             tail_v;
    logic [IDW-1:0]   tail_id;

    assign tail_v  = tag_v_q[LATENCY-1];
    assign tail_id = tag_id_q[LATENCY-1];

    // Grant search starts at ptr and wraps; the first requester found wins.
    always_comb begin
        int unsigned idx;
        idx    = 0;
        found  = 1'b0;
        gnt_id = '0;
        gnt_en = rstn && enable && (req != '0) && (out_cnt_q < CW'(MAX_OUT));
        for (int unsigned k = 0; k < NR; k++) begin
            idx = (32'(ptr_q) + k) % NR;
            if (!found && req[idx]) begin
                found  = 1'b1;
                gnt_id = IDW'(idx);
            end
        end
        gnt = '0;
        if (gnt_en) begin
            gnt[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_en) begin
            ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
        end

        out_cnt_d = out_cnt_q;
        case ({gnt_en, div_data_valid})
            2'b10:   out_cnt_d = out_cnt_q + CW'(1);
            2'b01:   out_cnt_d = (out_cnt_q != '0) ? out_cnt_q - CW'(1) : '0;
            default: out_cnt_d = out_cnt_q;
        endcase

        rsp_valid_d = '0;
        if (div_data_valid && tail_v) begin
            rsp_valid_d[tail_id] = 1'b1;
        end

        err_d = err_q | (div_data_valid != tail_v);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_q             <= '0;
            out_cnt_q         <= '0;
            div_start_q       <= 1'b0;
            div_dividend_q    <= '0;
            div_divisor_q     <= '0;
            issue_id_q        <= '0;
            tag_v_q           <= '0;
            rsp_valid_q       <= '0;
            rsp_quotient_q    <= '0;
            rsp_div_by_zero_q <= 1'b0;
            busy_q            <= 1'b0;
            err_q             <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_cnt_q   <= out_cnt_d;
            busy_q      <= (out_cnt_d != '0);
            err_q       <= err_d;
            div_start_q <= gnt_en;
            if (gnt_en) begin
                div_dividend_q <= req_dividend[gnt_id*WIDTH +: WIDTH];
                div_divisor_q  <= req_divisor[gnt_id*WIDTH +: WIDTH];
                issue_id_q     <= gnt_id;
            end
            // Stage 0 captures the start pulse so the tail lines up with div_data_valid.
            tag_v_q[0] <= div_start_q;
            for (int unsigned s = 1; s < LATENCY; s++) begin
                tag_v_q[s] <= tag_v_q[s-1];
            end
            rsp_valid_q <= rsp_valid_d;
            if (div_data_valid && tail_v) begin
                rsp_quotient_q    <= div_quotient;
                rsp_div_by_zero_q <= div_by_zero;
            end
        end
    end

    // Tag ids carry no meaning unless the matching valid bit is set, so they need no reset.
    always_ff @(posedge clk) begin
        tag_id_q[0] <= issue_id_q;
        for (int unsigned s = 1; s < LATENCY; s++) begin
            tag_id_q[s] <= tag_id_q[s-1];
        end
    end

    assign div_start       = div_start_q;
    assign div_dividend    = div_dividend_q;
    assign div_divisor     = div_divisor_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_quotient    = rsp_quotient_q;
    assign rsp_div_by_zero = rsp_div_by_zero_q;
    assign busy            = busy_q;
    assign err             = err_q;

endmodule

// File: tb/tb_ah_div_arbiter.sv
// Directed bench: two arbiters (MAX_OUT 11 and 3), each in front of a behavioural
// pipelined divider; expected values are hand-computed constants.
module tb_ah_div_arbiter;

    localparam int N   = 4;
    localparam int W   = 64;
    localparam int LAT = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rstn, enable, spur;
    logic [N-1:0]   req [2];
    logic [N*W-1:0] opd, ops;
    logic [N-1:0]   gnt [2];
    logic [N-1:0]   rv  [2];
    logic           ds  [2];
    logic [W-1:0]   ddvd[2];
    logic [W-1:0]   ddvs[2];
    logic           dv  [2];
    logic [W-1:0]   dq  [2];
    logic           dz  [2];
    logic [W-1:0]   rq  [2];
    logic           rz  [2];
    logic           busy[2];
    logic           err [2];

    int errors = 0;
    int checks = 0;

    ah_div_arbiter #(.NREQ(N), .WIDTH(W), .LATENCY(LAT), .MAX_OUT(11)) dut_a (
        .clk(clk), .rstn(rstn), .enable(enable), .req(req[0]),
        .req_dividend(opd), .req_divisor(ops), .gnt(gnt[0]),
        .div_start(ds[0]), .div_dividend(ddvd[0]), .div_divisor(ddvs[0]),
        .div_data_valid(dv[0]), .div_quotient(dq[0]), .div_by_zero(dz[0]),
        .rsp_valid(rv[0]), .rsp_quotient(rq[0]), .rsp_div_by_zero(rz[0]),
        .busy(busy[0]), .err(err[0])
    );

    ah_div_arbiter #(.NREQ(N), .WIDTH(W), .LATENCY(LAT), .MAX_OUT(3)) dut_b (
        .clk(clk), .rstn(rstn), .enable(enable), .req(req[1]),
        .req_dividend(opd), .req_divisor(ops), .gnt(gnt[1]),
        .div_start(ds[1]), .div_dividend(ddvd[1]), .div_divisor(ddvs[1]),
        .div_data_valid(dv[1]), .div_quotient(dq[1]), .div_by_zero(dz[1]),
        .rsp_valid(rv[1]), .rsp_quotient(rq[1]), .rsp_div_by_zero(rz[1]),
        .busy(busy[1]), .err(err[1])
    );

    // Behavioural divider: LAT-stage pipeline, not reset (results in flight survive a reset).
    logic         mv [2][LAT] = '{default: 1'b0};
    logic [W-1:0] mq [2][LAT];
    logic         mz [2][LAT];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int s = LAT - 1; s > 0; s--) begin
                mv[d][s] <= mv[d][s-1];
                mq[d][s] <= mq[d][s-1];
                mz[d][s] <= mz[d][s-1];
            end
            mv[d][0] <= (ds[d] === 1'b1);
            mz[d][0] <= (ddvs[d] == '0);
            mq[d][0] <= (ddvs[d] == '0) ? '1 : W'($signed(ddvd[d]) / $signed(ddvs[d]));
        end
    end

    assign dv[0] = mv[0][LAT-1] | spur;
    assign dv[1] = mv[1][LAT-1];
    assign dq[0] = mq[0][LAT-1];
    assign dq[1] = mq[1][LAT-1];
    assign dz[0] = mz[0][LAT-1];
    assign dz[1] = mz[1][LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        opd[i*W +: W] = a;
        ops[i*W +: W] = b;
    endtask

    logic [W-1:0] rr_q [4] = '{64'd50, 64'd66, 64'd75, 64'd80};
    logic [N-1:0] cr_g [17] = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000,
                                4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0000};
    logic         any_rsp;
    logic [1:0]   maxc;
    int           budget;

    initial begin
        rstn = 1'b0; enable = 1'b1; spur = 1'b0;
        req[0] = '0; req[1] = '0; opd = '0; ops = '0;
        tick(); tick(); #1;

        chk("rst_gnt", W'(gnt[0]), 0);
        chk("rst_start", W'(ds[0]), 0);
        chk("rst_dividend", ddvd[0], 0);
        chk("rst_rsp_valid", W'(rv[0]), 0);
        chk("rst_rsp_q", rq[0], 0);
        chk("rst_busy", W'(busy[0]), 0);
        chk("rst_err", W'(err[0]), 0);
        rstn = 1'b1;

        // single request: requester 2, -100 / 7
        tick(); set_op(2, -64'sd100, 64'sd7); req[0] = 4'b0100; #1;
        chk("single_gnt", W'(gnt[0]), 4'b0100);
        tick(); req[0] = '0; #1;
        chk("single_start", W'(ds[0]), 1);
        chk("single_dividend", ddvd[0], -64'sd100);
        chk("single_divisor", ddvs[0], 64'sd7);
        chk("single_busy", W'(busy[0]), 1);
        repeat (11) tick();
        #1;
        chk("single_rsp_early", W'(rv[0]), 0);
        tick(); #1;
        chk("single_rsp_valid", W'(rv[0]), 4'b0100);
        chk("single_rsp_q", rq[0], -64'sd14);
        chk("single_rsp_dbz", W'(rz[0]), 0);
        chk("single_busy_done", W'(busy[0]), 0);
        tick(); #1;
        chk("single_rsp_once", W'(rv[0]), 0);

        enable = 1'b0; req[0] = 4'b1111; #1;
        chk("enable_off_gnt", W'(gnt[0]), 0);
        enable = 1'b1; req[0] = '0;

        // round robin from a freshly reset pointer
        tick(); rstn = 1'b0; tick(); rstn = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, W'(100 * (i + 1)), W'(i + 2));
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            req[0] = 4'b1111; #1;
            chk("rr_gnt", W'(gnt[0]), W'(1 << (k % 4)));
        end
        tick(); req[0] = '0;
        repeat (4) tick();
        for (int k = 0; k < 8; k++) begin
            tick(); #1;
            chk("rr_rsp_valid", W'(rv[0]), W'(1 << (k % 4)));
            chk("rr_rsp_q", rq[0], rr_q[k % 4]);
        end

        // divide by zero on requester 1
        tick(); set_op(1, 64'sd5, 64'sd0); req[0] = 4'b0010; #1;
        chk("dbz_gnt", W'(gnt[0]), 4'b0010);
        tick(); req[0] = '0;
        repeat (11) tick();
        tick(); #1;
        chk("dbz_rsp_valid", W'(rv[0]), 4'b0010);
        chk("dbz_flag", W'(rz[0]), 1);

        // reset mid-flight: pointer is 2, so requesters 0 then 1 win
        tick(); req[0] = 4'b0011; #1;
        chk("mid_gnt0", W'(gnt[0]), 4'b0001);
        tick(); #1;
        chk("mid_gnt1", W'(gnt[0]), 4'b0010);
        tick(); req[0] = '0;
        repeat (4) tick();
        rstn = 1'b0; req[0] = 4'b1111; #1;
        chk("mid_rst_gnt", W'(gnt[0]), 0);
        tick(); rstn = 1'b1; req[0] = '0; #1;
        chk("mid_busy", W'(busy[0]), 0);
        chk("mid_ptr", W'(dut_a.ptr_q), 0);
        chk("mid_start", W'(ds[0]), 0);
        any_rsp = 1'b0;
        repeat (8) begin
            tick(); #1;
            if (rv[0] != '0) any_rsp = 1'b1;
        end
        chk("mid_no_rsp", W'(any_rsp), 0);
        chk("mid_stray_err", W'(err[0]), 1);
        chk("mid_busy_end", W'(busy[0]), 0);

        // spurious div_data_valid with empty tag line
        tick(); rstn = 1'b0; tick(); rstn = 1'b1; #1;
        chk("mis_err_clear", W'(err[0]), 0);
        tick(); spur = 1'b1; tick(); spur = 1'b0; #1;
        chk("mis_err", W'(err[0]), 1);
        chk("mis_no_rsp", W'(rv[0]), 0);
        repeat (3) tick();
        #1;
        chk("mis_err_sticky", W'(err[0]), 1);
        chk("mis_no_rsp_late", W'(rv[0]), 0);
        chk("mis_busy", W'(busy[0]), 0);

        // credit limit on the MAX_OUT=3 instance
        tick();
        for (int i = 0; i < N; i++) set_op(i, W'(10 * (i + 1)), 64'd1);
        maxc = '0;
        for (int k = 0; k < 17; k++) begin
            if (k > 0) tick();
            req[1] = 4'b1111; #1;
            chk("credit_gnt", W'(gnt[1]), W'(cr_g[k]));
            if (dut_b.out_cnt_q > maxc) maxc = dut_b.out_cnt_q;
            if (k == 13) chk("credit_rsp", W'(rv[1]), 4'b0001);
        end
        chk("credit_max_out", W'(maxc), 3);
        tick(); req[1] = '0;
        budget = 0;
        while (busy[1] !== 1'b0 && budget < 40) begin
            tick();
            budget++;
        end
        #1;
        chk("credit_drain", W'(busy[1]), 0);
        chk("credit_err", W'(err[1]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ah_div_arbiter.md
# ah_div_arbiter

Shares one pipelined signed divider among `NREQ` requesters. Each cycle the block arbitrates round-robin, issues at most one operation into the divider, and tracks the requester ID of every in-flight operation in a tag delay line matched to the divider latency. When the result emerges, the block routes it back to the requester that issued it. It sits between the client blocks and the divider instance and is the only driver of the divider's `start`/operand inputs.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..16.
- `WIDTH`, default 64: operand and quotient width.
- `LATENCY`, default 11: cycles from divider `start` sampled to `data_valid`; must match the divider instance.
- `MAX_OUT`, default 11: maximum operations in flight, 1..`LATENCY`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: synchronous active-low reset, sampled on the rising edge of `clk`.
- `enable` in 1: grants allowed while 1; in-flight operations always complete.
- `req` in `NREQ`: request per requester; held high until granted.
- `req_dividend` in `NREQ*WIDTH`: flat operands; requester i uses bits `[i*WIDTH +: WIDTH]`.
- `req_divisor` in `NREQ*WIDTH`: same packing as `req_dividend`.
- `gnt` out `NREQ`: one-hot or zero, combinational; requester i's operands are consumed in any cycle where `gnt[i]`=1.
- `div_start` out 1: registered start pulse to the divider.
- `div_dividend` out `WIDTH`: registered operand to the divider.
- `div_divisor` out `WIDTH`: registered operand to the divider.
- `div_data_valid` in 1: result valid from the divider.
- `div_quotient` in `WIDTH`: result from the divider.
- `div_by_zero` in 1: divide-by-zero flag from the divider, qualified by `div_data_valid`.
- `rsp_valid` out `NREQ`: one-hot or zero, registered response strobe.
- `rsp_quotient` out `WIDTH`: registered; valid only while any `rsp_valid` bit is 1.
- `rsp_div_by_zero` out 1: registered; valid only while any `rsp_valid` bit is 1.
- `busy` out 1: registered; 1 while `out_cnt` is nonzero.
- `err` out 1: sticky; set on any tag/result misalignment.

## Operation
- **Grant condition.** A grant occurs iff `enable`=1, `req`≠0, and `out_cnt` < `MAX_OUT`.
- **Round-robin pointer.** `ptr` resets to 0. The requester granted is the first i with `req[i]`=1, searching from `ptr` upward and wrapping modulo `NREQ`. After a grant to i, `ptr` becomes (i+1) mod `NREQ`. With no grant, `ptr` holds.
- **Issue.** On a grant to i, the next cycle has `div_start`=1 with `div_dividend`/`div_divisor` equal to requester i's operands. In all other cycles `div_start`=0 and the operand registers hold their last values.
- **Tag delay line.** The line is `LATENCY` stages of {valid, id of $clog2(`NREQ`) bits}. It shifts every cycle. Stage 0 loads {`div_start`, granted id}, so the tail stage is aligned with `div_data_valid` for that operation.
- **Response.** When `div_data_valid`=1 and the tail tag is valid: next cycle `rsp_valid[tail id]`=1, and `rsp_quotient`/`rsp_div_by_zero` are registered from the divider outputs.
- **Error detection.** If `div_data_valid` ≠ tail valid in any cycle, `err` is set. When `div_data_valid`=1 but the tail is invalid, no response is generated. `err` clears only on reset.
- **Outstanding counter.** `out_cnt` has width $clog2(`MAX_OUT`+1). It increments on a grant and decrements on `div_data_valid`. When both happen in the same cycle it is unchanged. It saturates at 0 and never exceeds `MAX_OUT`.
- **Arithmetic.** The block performs no arithmetic on data; operands and results pass through unmodified.

## Timing
- **Reset values.** All outputs reset to 0: `gnt` (with `req`=0), `div_start`, `div_dividend`, `div_divisor`, `rsp_valid`, `rsp_quotient`, `rsp_div_by_zero`, `busy`, `err`. `ptr`=0, `out_cnt`=0, all tag valid bits 0.
- **`gnt` during reset.** `gnt` is forced to 0 while `rstn`=0.
- **Latency.** `req` high with a grant at cycle t, then `div_start` at t+1, then `div_data_valid` at t+1+`LATENCY`, then `rsp_valid` at t+2+`LATENCY`. Total: `LATENCY`+2 cycles from grant to response.
- **Throughput.** One grant per cycle; back-to-back grants are allowed.
- **Simultaneous events.** A grant and a response to the same requester in the same cycle are both honoured.
- **`enable` deasserted mid-stream.** No new grants; in-flight operations drain normally.
- **Reset mid-operation.** All in-flight tags are discarded. Divider results arriving after reset are flagged via `err` only if `div_data_valid` is seen while the tail is invalid.
- **Requester drops `req` before a grant.** The request is withdrawn; no state changes.

## Test plan
- **Single request.** Reset, then `req`=4'b0100 for one cycle with dividend -100 and divisor 7 → `gnt`=4'b0100 at t, `div_start` at t+1 with those operands, `rsp_valid`=4'b0100 at t+13, `rsp_quotient`=-14.
- **Round-robin fairness.** All four `req` held high for 8 cycles → grant sequence 0,1,2,3,0,1,2,3. Each response returns to the correct requester exactly 13 cycles after its grant.
- **Credit limit.** `MAX_OUT`=3, all `req` held high → 3 grants, then none until the first `div_data_valid`. After that, one grant per returning result. `out_cnt` never exceeds 3.
- **Divide by zero.** Requester 1 issues 5/0 → `rsp_valid`=4'b0010 with `rsp_div_by_zero`=1 after 13 cycles.
- **Reset mid-flight.** Assert `rstn`=0 for 1 cycle, 5 cycles after 2 grants → no `rsp_valid` afterwards, `busy`=0 and `ptr`=0 after reset.
- **Misalignment.** Inject a spurious `div_data_valid` with an empty tag line → `err`=1 the next cycle and stays 1; no `rsp_valid` is generated.
